result_collector_4x4: RTL

//  Downstream of the 4x4 matrix handler. Gathers the 16 signed 32-bit

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/result_collector_4x4_if.sv | 36 +++
 rtl/rc_write_resolve.sv | 55 +++++
 rtl/result_collector_4x4.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state type and index helper
// for the 4x4 result collector.
package matrix_pkg;
  localparam int DATA_W  = 32;
  localparam int N       = 4;
  localparam int NUM_SRC = 4;
  localparam int NE      = N * N;
  localparam int IDX_W   = $clog2(NE);
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int CNT_W   = $clog2(NE + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } coll_state_t;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;

  function automatic idx_t idx(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return idx_t'(row) * idx_t'(N) + idx_t'(col);
  endfunction
endpackage

// File: rtl/result_collector_4x4_if.sv
// Element-in / matrix-out bundle of the collector.
// slave is the collector side, master the producer/consumer side.
interface result_collector_4x4_if;
  import matrix_pkg::*;

  logic                      start;
  logic [NUM_SRC-1:0]        res_valid;
  logic [NUM_SRC*DATA_W-1:0] res_data;
  logic [NUM_SRC*2-1:0]      res_row;
  logic [NUM_SRC*2-1:0]      res_col;
  logic [NUM_SRC-1:0]        res_ack;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [1:0]                out_row;
  logic [1:0]                out_col;
  logic                      out_ready;
  logic [CNT_W-1:0]          fill_count;
  logic                      err_dup;
  logic                      done;

  modport master (
    output start, res_valid, res_data,
    output res_row, res_col, out_ready,
    input  res_ack, out_valid, out_data,
    input  out_row, out_col,
    input  fill_count, err_dup, done
  );

  modport slave (
    input  start, res_valid, res_data,
    input  res_row, res_col, out_ready,
    output res_ack, out_valid, out_data,
    output out_row, out_col,
    output fill_count, err_dup, done
  );
endinterface

// File: rtl/rc_write_resolve.sv
// Per-cycle write arbitration: maps accepted beats to buffer entries,
// lowest source wins a shared entry, filled entries are never rewritten.
module rc_write_resolve
  import matrix_pkg::*;
(
  input  logic [NUM_SRC-1:0]            valid,
  input  logic [NUM_SRC*2-1:0]          row,
  input  logic [NUM_SRC*2-1:0]          col,
  input  logic [NE-1:0]                 bitmap,
  output logic [NE-1:0]                 we,
  output logic [NE-1:0][SRC_W-1:0]      sel,
  output logic [2:0]                    new_cnt,
  output logic                          dup
);

  logic [NUM_SRC-1:0][IDX_W-1:0] six;
  logic [NUM_SRC-1:0]            win;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      six[s] = idx(row[s*2 +: 2], col[s*2 +: 2]);
    end
  end

  // A source wins if its entry is empty and no lower source claims it
  always_comb begin
    win = '0;
    dup = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      win[s] = valid[s] && !bitmap[six[s]];
      for (int t = 0; t < NUM_SRC; t++) begin
        if (t < s && valid[t] && six[t] == six[s]) begin
          win[s] = 1'b0;
        end
      end
      if (valid[s] && !win[s]) begin
        dup = 1'b1;
      end
    end
  end

  always_comb begin
    we      = '0;
    sel     = '0;
    new_cnt = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (win[s]) begin
        we[six[s]]  = 1'b1;
        sel[six[s]] = SRC_W'(s);
        new_cnt     = new_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/result_collector_4x4.sv
// Collects 16 out-of-order result elements into a 4x4 buffer,
// then streams the matrix out row-major and flags done.
module result_collector_4x4
  import matrix_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  result_collector_4x4_if.slave bus
);

  coll_state_t      state_q, state_d;
  logic [NE-1:0]    bitmap_q, bitmap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  idx_t             ptr_q, ptr_d;
  logic             err_q, err_d;
  data_t            buf_q [NE];
  data_t            buf_d [NE];

  data_t                    src_data [NUM_SRC];
  logic                     collect_en;
  logic [NUM_SRC-1:0]       ack;
  logic [NE-1:0]            we;
  logic [NE-1:0][SRC_W-1:0] sel;
  logic [2:0]               new_cnt;
  logic                     dup;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     fill_done;
  logic                     drain_hs;
  logic                     last_hs;

  assign collect_en = state_q == COLLECT && !bus.start && !rst;
  assign ack        = bus.res_valid & {NUM_SRC{collect_en}};
  assign cnt_nxt    = cnt_q + CNT_W'(new_cnt);
  assign fill_done  = collect_en && cnt_nxt == CNT_W'(NE);
  assign drain_hs   = state_q == DRAIN && bus.out_ready;
  assign last_hs    = drain_hs && ptr_q == idx_t'(NE - 1)
                      && !bus.start;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      src_data[s] = bus.res_data[s*DATA_W +: DATA_W];
    end
  end

  rc_write_resolve u_resolve (
    .valid   (ack),
    .row     (bus.res_row),
    .col     (bus.res_col),
    .bitmap  (bitmap_q),
    .we      (we),
    .sel     (sel),
    .new_cnt (new_cnt),
    .dup     (dup)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      bus.start: state_d = COLLECT;
      fill_done: state_d = DRAIN;
      last_hs:   state_d = DONE;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    buf_d    = buf_q;
    for (int e = 0; e < NE; e++) begin
      if (we[e]) begin
        buf_d[e] = src_data[sel[e]];
      end
    end
    if (bus.start) begin
      bitmap_d = '0;
      cnt_d    = '0;
      ptr_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (collect_en) begin
        bitmap_d = bitmap_q | we;
        cnt_d    = cnt_nxt;
        err_d    = err_q | dup;
      end
      if (fill_done) begin
        ptr_d = '0;
      end
      if (drain_hs) begin
        ptr_d = ptr_q + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage only; validity is tracked by the bitmap
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    bus.res_ack    = ack;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_row    = '0;
    bus.out_col    = '0;
    bus.done       = 1'b0;
    bus.fill_count = cnt_q;
    bus.err_dup    = err_q;
    unique case (state_q)
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = buf_q[ptr_q];
        bus.out_row   = ptr_q[3:2];
        bus.out_col   = ptr_q[1:0];
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
